line_sense: RTL and testbench
=============================

LINE_SENSE -- requirements
Module: line_sense

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter W, default 17, SHALL set the width of each time-to-decay (ttd) channel.
REQ-003 Parameter DB_CYCLES, default 160000, SHALL set the debounce hold length in clocks.
REQ-004 Parameter CAL_SAMPLES, default 16, SHALL set the number of scans used for calibration (range 1..255).
REQ-005 Parameter FIXED_THRESH, default 20'd2000, SHALL set the threshold used when autocal is compiled out.
REQ-006 WF_CLK  in  1  system clock.
REQ-007 rst_n  in  1  asynchronous reset, active low.
REQ-008 ttd_bus  in  8*W  channels 0..7; channel k is at bits [k*W +: W].
REQ-009 sample_valid  in  1  one-clock pulse; ttd_bus holds a new scan.
REQ-010 cal_start  in  1  one-clock pulse that requests calibration.
REQ-011 threshold  out  20  active threshold.
REQ-012 cal_done  out  1  high while the threshold is valid.
REQ-013 ir_color  out  8  registered classification per channel; 1 = black.
REQ-014 left_sum, right_sum  out  3 each  popcount of ir_color[7:4] and ir_color[3:0].
REQ-015 on_track, lost, pos_ok, goal, right, left  out  1 each  debounced pattern flags.

Function
REQ-016 The FSM SHALL have three states: IDLE, CAL and RUN.
REQ-017 In IDLE, cal_start SHALL move the FSM to CAL, set min to all ones, set max to 0, set the count to 0 and clear cal_done.
REQ-018 In CAL, each sample_valid SHALL update min/max against the smallest and largest of the 8 channels in that scan and increment the count.
REQ-019 When the count reaches CAL_SAMPLES, the block SHALL register threshold = (3*min + max) >> 2 in 20-bit zero-extended arithmetic, set cal_done, and enter RUN on the same edge.
REQ-020 cal_start in CAL or RUN SHALL restart CAL (per REQ-017) in the next cycle; a sample_valid in that same cycle SHALL be ignored.
REQ-021 In RUN, each sample_valid SHALL register ir_color[k] = (ttd_k > threshold); in all other cycles ir_color SHALL hold its value.
REQ-022 In IDLE and CAL, ir_color SHALL be held at 0.
REQ-023 The raw patterns, derived from ir_color, SHALL be:
- on_track = c[3] | c[4]
- lost = (c == 0)
- pos_ok = (c[3] | c[4]) & (c[7:5] == {c[0], c[1], c[2]})
- goal = c[0] & c[7] & ~&c
- right = (c[3:0] == 4'hF)
- left = (c[7:4] == 4'hF)
REQ-024 Each flag SHALL change to its raw value only after the raw value has differed from the flag for DB_CYCLES consecutive clocks; any match SHALL reset that flag's counter.
REQ-025 left_sum and right_sum SHALL be combinational from ir_color and SHALL NOT be debounced.
REQ-026 After the FSM leaves RUN for CAL, the flags SHALL continue debouncing toward the values implied by ir_color = 0.

Reset
REQ-027 rst_n low SHALL force, asynchronously: FSM to IDLE, threshold = 0, cal_done = 0, ir_color = 0, min all ones, max = 0, count = 0, and all debounce counters = 0.
REQ-028 rst_n low SHALL force on_track, pos_ok, goal, right and left to 0, and lost to 1.
REQ-029 A reset during CAL SHALL discard the partial min/max.

Configuration
REQ-030 With macro LINE_SENSE_AUTOCAL_EN defined, the behaviour SHALL be as specified above.
REQ-031 Without LINE_SENSE_AUTOCAL_EN:
- the CAL state and min/max logic SHALL be absent;
- threshold SHALL be FIXED_THRESH;
- cal_done SHALL be 1 after reset;
- the FSM SHALL enter RUN on the first clock after reset release;
- cal_start SHALL be ignored.

Verification
Bench parameters for all scenarios: W = 17, DB_CYCLES = 4, CAL_SAMPLES = 4, LINE_SENSE_AUTOCAL_EN defined unless stated.
REQ-032 Calibration: pulse cal_start, then drive 4 scans containing values 100..900 -> threshold = 300 and cal_done = 1 on the edge of the 4th sample_valid.
REQ-033 Classification: with threshold = 300, a scan with channels 3 and 4 = 900 and the rest = 100 -> ir_color = 8'h18; on_track and pos_ok rise 4 clocks after that, and lost falls.
REQ-034 Glitch rejection: a raw lost pattern held for 3 clocks and then removed -> lost never asserts.
REQ-035 Recalibration: cal_start in RUN with 2 scans pending -> cal_done falls next cycle, the pending scans are not classified, and the threshold updates after 4 new scans.
REQ-036 Reset mid-CAL: assert rst_n low after 2 samples -> all outputs at reset values immediately; a later calibration uses fresh min/max.
REQ-037 Autocal compiled out: with the macro undefined and FIXED_THRESH = 500, a scan of all channels = 600 -> ir_color = 8'hFF, and after 4 clocks goal = 0, right = 1, left = 1.

Source files
------------

// File: rtl/line_sense_if.sv
`default_nettype none
// ============================================================================
// line_sense_if : scan input / classification output bundle for line_sense
// Rev 1.0
// ============================================================================
interface line_sense_if #(
  parameter int W = 17
);
  logic [8*W-1:0] ttd_bus;
  logic           sample_valid;
  logic           cal_start;
  logic [19:0]    threshold;
  logic           cal_done;
  logic [7:0]     ir_color;
  logic [2:0]     left_sum;
  logic [2:0]     right_sum;
  logic           on_track;
  logic           lost;
  logic           pos_ok;
  logic           goal;
  logic           right;
  logic           left;

  modport master (
    output ttd_bus, sample_valid, cal_start,
    input  threshold, cal_done, ir_color, left_sum, right_sum,
    input  on_track, lost, pos_ok, goal, right, left
  );

  modport slave (
    input  ttd_bus, sample_valid, cal_start,
    output threshold, cal_done, ir_color, left_sum, right_sum,
    output on_track, lost, pos_ok, goal, right, left
  );
endinterface
`default_nettype wire

// File: rtl/line_sense.sv
`default_nettype none
// ============================================================================
// line_sense : 8-channel IR line classifier with debounced pattern flags.
//   Define LINE_SENSE_AUTOCAL_EN to build the min/max auto-calibration path.
// Rev 1.0
// ============================================================================
module line_sense #(
  parameter int          W            = 17,
  parameter int          DB_CYCLES    = 160000,
  parameter int          CAL_SAMPLES  = 16,
  parameter logic [19:0] FIXED_THRESH = 20'd2000
) (
  input  wire logic   WF_CLK,
  input  wire logic   rst_n,
  line_sense_if.slave bus
);

  localparam int CW  = (W > 20) ? W : 20;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

`ifdef LINE_SENSE_AUTOCAL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CAL = 2'd1, ST_RUN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd2} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_ir_color, w_ir_nxt;
  logic [7:0]  w_class;
  logic [19:0] w_threshold;
  logic        w_cal_done;
  logic        w_unused;

  always_comb begin
    w_class = '0;
    for (int k = 0; k < 8; k++)
      w_class[k] = CW'(bus.ttd_bus[k*W +: W]) > CW'(w_threshold);
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

`ifdef LINE_SENSE_AUTOCAL_EN
  logic [W-1:0] r_min, r_max, w_min_nxt, w_max_nxt;
  logic [W-1:0] w_scan_min, w_scan_max, w_acc_min, w_acc_max;
  logic [7:0]   r_cnt, w_cnt_nxt;
  logic [19:0]  r_threshold, w_thresh_nxt;
  logic         r_cal_done, w_cal_done_nxt;

  always_comb begin
    w_scan_min = bus.ttd_bus[W-1:0];
    w_scan_max = bus.ttd_bus[W-1:0];
    for (int k = 1; k < 8; k++) begin
      if (bus.ttd_bus[k*W +: W] < w_scan_min) w_scan_min = bus.ttd_bus[k*W +: W];
      if (bus.ttd_bus[k*W +: W] > w_scan_max) w_scan_max = bus.ttd_bus[k*W +: W];
    end
    w_acc_min = (w_scan_min < r_min) ? w_scan_min : r_min;
    w_acc_max = (w_scan_max > r_max) ? w_scan_max : r_max;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_min_nxt      = r_min;
    w_max_nxt      = r_max;
    w_cnt_nxt      = r_cnt;
    w_thresh_nxt   = r_threshold;
    w_cal_done_nxt = r_cal_done;
    w_ir_nxt       = r_ir_color;
    case (r_state)
      ST_IDLE: ;
      ST_CAL: begin
        if (!bus.cal_start && bus.sample_valid) begin
          w_min_nxt = w_acc_min;
          w_max_nxt = w_acc_max;
          w_cnt_nxt = r_cnt + 8'd1;
          if (w_cnt_nxt == 8'(CAL_SAMPLES)) begin
            w_thresh_nxt   = (20'(w_acc_min) * 20'd3 + 20'(w_acc_max)) >> 2;
            w_cal_done_nxt = 1'b1;
            w_state_nxt    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!bus.cal_start && bus.sample_valid) w_ir_nxt = w_class;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A calibration request wins over any scan arriving in the same cycle.
    if (bus.cal_start) begin
      w_state_nxt    = ST_CAL;
      w_min_nxt      = '1;
      w_max_nxt      = '0;
      w_cnt_nxt      = '0;
      w_cal_done_nxt = 1'b0;
    end
    if (w_state_nxt != ST_RUN) w_ir_nxt = '0;
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_min       <= '1;
      r_max       <= '0;
      r_cnt       <= '0;
      r_threshold <= '0;
      r_cal_done  <= 1'b0;
      r_ir_color  <= '0;
    end else begin
      r_min       <= w_min_nxt;
      r_max       <= w_max_nxt;
      r_cnt       <= w_cnt_nxt;
      r_threshold <= w_thresh_nxt;
      r_cal_done  <= w_cal_done_nxt;
      r_ir_color  <= w_ir_nxt;
    end
  end

  assign w_threshold = r_threshold;
  assign w_cal_done  = r_cal_done;
  assign w_unused    = &{1'b0, FIXED_THRESH};
`else
  always_comb begin
    w_state_nxt = ST_RUN;
    w_ir_nxt    = '0;
    if (r_state == ST_RUN) w_ir_nxt = bus.sample_valid ? w_class : r_ir_color;
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) r_ir_color <= '0;
    else        r_ir_color <= w_ir_nxt;
  end

  assign w_threshold = FIXED_THRESH;
  assign w_cal_done  = 1'b1;
  assign w_unused    = &{1'b0, bus.cal_start, (CAL_SAMPLES == 0)};
`endif

  // Flag order: {left, right, goal, pos_ok, lost, on_track}
  logic [5:0]     w_raw, r_flag;
  logic [DBW-1:0] r_db_cnt [6];

  always_comb begin
    w_raw[0] = r_ir_color[3] | r_ir_color[4];
    w_raw[1] = (r_ir_color == 8'h00);
    w_raw[2] = (r_ir_color[3] | r_ir_color[4]) &
               (r_ir_color[7:5] == {r_ir_color[0], r_ir_color[1], r_ir_color[2]});
    w_raw[3] = r_ir_color[0] & r_ir_color[7] & ~&r_ir_color;
    w_raw[4] = (r_ir_color[3:0] == 4'hF);
    w_raw[5] = (r_ir_color[7:4] == 4'hF);
  end

  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 6'b000010;
      for (int f = 0; f < 6; f++) r_db_cnt[f] <= '0;
    end else begin
      for (int f = 0; f < 6; f++) begin
        if (w_raw[f] == r_flag[f]) begin
          r_db_cnt[f] <= '0;
        end else if (r_db_cnt[f] == DBW'(DB_CYCLES - 1)) begin
          r_flag[f]   <= w_raw[f];
          r_db_cnt[f] <= '0;
        end else begin
          r_db_cnt[f] <= r_db_cnt[f] + DBW'(1);
        end
      end
    end
  end

  assign bus.threshold = w_threshold;
  assign bus.cal_done  = w_cal_done;
  assign bus.ir_color  = r_ir_color;
  assign bus.left_sum  = 3'(r_ir_color[7]) + 3'(r_ir_color[6]) + 3'(r_ir_color[5]) + 3'(r_ir_color[4]);
  assign bus.right_sum = 3'(r_ir_color[3]) + 3'(r_ir_color[2]) + 3'(r_ir_color[1]) + 3'(r_ir_color[0]);
  assign bus.on_track  = r_flag[0];
  assign bus.lost      = r_flag[1];
  assign bus.pos_ok    = r_flag[2];
  assign bus.goal      = r_flag[3];
  assign bus.right     = r_flag[4];
  assign bus.left      = r_flag[5];

endmodule
`default_nettype wire

// File: tb/tb_line_sense.sv
`default_nettype none
// tb_line_sense : randomized self-checking bench; line_sense is compared each
// cycle against a scan-level model (sample queues, popcounts, mismatch history).
module tb_line_sense;
  localparam int          W    = 17;
  localparam int          DB   = 4;
  localparam int          CALN = 4;
  localparam logic [19:0] FT   = 20'd500;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_sense_if #(.W(W)) bus ();

  line_sense #(
    .W(W), .DB_CYCLES(DB), .CAL_SAMPLES(CALN), .FIXED_THRESH(FT)
  ) dut (
    .WF_CLK(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int         ttd [8];
  int         m_mode;    // 0 idle, 1 calibrating, 2 running
  int         m_thresh;
  bit         m_done;
  bit [7:0]   m_color;
  bit [5:0]   m_flag;    // {left, right, goal, pos_ok, lost, on_track}
  bit [5:0]   m_hist[$];
  int         m_scan[$];

  function automatic bit [5:0] raw_of(input bit [7:0] c);
    bit sym = 1'b1;
    for (int i = 0; i < 3; i++) if (c[7-i] != c[i]) sym = 1'b0;
    raw_of[0] = c[3] || c[4];
    raw_of[1] = (c == 8'h00);
    raw_of[2] = (c[3] || c[4]) && sym;
    raw_of[3] = c[0] && c[7] && (c != 8'hFF);
    raw_of[4] = ($countones(c[3:0]) == 4);
    raw_of[5] = ($countones(c[7:4]) == 4);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_scan.delete();
    m_hist.delete();
    m_color = '0;
    m_flag  = 6'b000010;
`ifdef LINE_SENSE_AUTOCAL_EN
    m_thresh = 0;
    m_done   = 1'b0;
`else
    m_thresh = int'(FT);
    m_done   = 1'b1;
`endif
  endtask

  task automatic model_edge(input bit sv, input bit cs);
    bit [5:0] raw = raw_of(m_color);
    bit [7:0] cls;
    m_hist.push_back(raw);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    if (m_hist.size() == DB) begin
      for (int f = 0; f < 6; f++) begin
        bit all_diff = 1'b1;
        foreach (m_hist[j]) if (m_hist[j][f] == m_flag[f]) all_diff = 1'b0;
        if (all_diff) m_flag[f] = raw[f];
      end
    end
    for (int k = 0; k < 8; k++) cls[k] = (ttd[k] > m_thresh);
`ifdef LINE_SENSE_AUTOCAL_EN
    if (cs) begin
      m_mode = 1;
      m_scan.delete();
      m_done = 1'b0;
    end else if (m_mode == 1 && sv) begin
      for (int k = 0; k < 8; k++) m_scan.push_back(ttd[k]);
      if (m_scan.size() == 8 * CALN) begin
        int lo = m_scan[0];
        int hi = m_scan[0];
        foreach (m_scan[j]) begin
          if (m_scan[j] < lo) lo = m_scan[j];
          if (m_scan[j] > hi) hi = m_scan[j];
        end
        m_thresh = (3 * lo + hi) / 4;
        m_done   = 1'b1;
        m_mode   = 2;
      end
    end else if (m_mode == 2 && sv) begin
      m_color = cls;
    end
`else
    if (m_mode == 2 && sv) m_color = cls;
    m_mode = 2;
`endif
    if (m_mode != 2) m_color = '0;
  endtask

  function automatic bit [40:0] dut_outs();
    return {bus.threshold, bus.cal_done, bus.ir_color, bus.left_sum, bus.right_sum,
            bus.left, bus.right, bus.goal, bus.pos_ok, bus.lost, bus.on_track};
  endfunction

  function automatic bit [40:0] model_outs();
    return {20'(m_thresh), m_done, m_color, 3'($countones(m_color[7:4])),
            3'($countones(m_color[3:0])), m_flag};
  endfunction

  task automatic cyc(input bit sv, input bit cs);
    bus.sample_valid = sv;
    bus.cal_start    = cs;
    for (int k = 0; k < 8; k++) bus.ttd_bus[k*W +: W] = W'(ttd[k]);
    @(posedge clk);
    if (rst_n) model_edge(sv, cs);
    #1;
    bus.sample_valid = 1'b0;
    bus.cal_start    = 1'b0;
  endtask

  task automatic set_pattern(input bit [7:0] pat, input int lo, input int hi);
    for (int k = 0; k < 8; k++) ttd[k] = pat[k] ? hi : lo;
  endtask

  task automatic set_cal_scan(input int lo, input int hi);
    int a = int'($urandom_range(7, 0));
    int b = (a + 1 + int'($urandom_range(6, 0))) % 8;
    for (int k = 0; k < 8; k++) ttd[k] = int'($urandom_range(hi, lo));
    ttd[a] = lo;
    ttd[b] = hi;
  endtask

  task automatic set_random_scan();
    bit [7:0] pats [8] = '{8'h00, 8'h18, 8'hFF, 8'h0F, 8'hF0, 8'h81, 8'h99, 8'h3C};
    bit [7:0] pat = ($urandom_range(3, 0) == 0) ? 8'($urandom) : pats[$urandom_range(7, 0)];
    for (int k = 0; k < 8; k++)
      ttd[k] = pat[k] ? int'($urandom_range(1000, m_thresh + 1)) : int'($urandom_range(m_thresh, 0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (dut_outs() !== model_outs())
      $display("FAIL reset_outs: got %h want %h", dut_outs(), model_outs());
    else n_pass++;
    n_checks++;
    if (bus.lost !== 1'b1 || bus.ir_color !== 8'h00 || bus.on_track !== 1'b0)
      $display("FAIL reset_flags: lost=%b ir=%h on_track=%b want 1/00/0", bus.lost, bus.ir_color, bus.on_track);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0);
      n_checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL post_reset cyc %0d: got %h want %h", i, dut_outs(), model_outs());
      else n_pass++;
    end
  endtask

`ifdef LINE_SENSE_AUTOCAL_EN
  task automatic run_cal(input string tag, input int lo, input int hi, input int want);
    cyc(1'b0, 1'b1);
    for (int s = 0; s < CALN; s++) begin
      repeat ($urandom_range(2, 0)) cyc(1'b0, 1'b0);
      set_cal_scan(lo, hi);
      cyc(1'b1, 1'b0);
      n_checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL %s scan %0d: got %h want %h", tag, s, dut_outs(), model_outs());
      else n_pass++;
    end
    n_checks++;
    if (bus.threshold !== 20'(want) || bus.cal_done !== 1'b1)
      $display("FAIL %s_thresh: got %0d/%b want %0d/1", tag, bus.threshold, bus.cal_done, want);
    else n_pass++;
  endtask

  task automatic test_calibration();
    run_cal("cal", 100, 900, 300);
  endtask

  task automatic test_classify();
    set_pattern(8'h18, 100, 900);
    cyc(1'b1, 1'b0);
    n_checks++;
    if (bus.ir_color !== 8'h18) $display("FAIL classify_ir: got %h want 18", bus.ir_color);
    else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0);
      n_checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL classify cyc %0d: got %h want %h", i, dut_outs(), model_outs());
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (bus.on_track !== 1'b0 || bus.lost !== 1'b1)
          $display("FAIL classify_early: on_track=%b lost=%b want 0/1", bus.on_track, bus.lost);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (bus.on_track !== 1'b1 || bus.pos_ok !== 1'b1 || bus.lost !== 1'b0)
          $display("FAIL classify_rise: on_track=%b pos_ok=%b lost=%b want 1/1/0", bus.on_track, bus.pos_ok, bus.lost);
        else n_pass++;
      end
    end
  endtask

  task automatic test_glitch();
    set_pattern(8'h00, 100, 900);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    set_pattern(8'h18, 100, 900);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.lost !== 1'b0 || dut_outs() !== model_outs())
        $display("FAIL glitch cyc %0d: lost=%b got %h want %h", i, bus.lost, dut_outs(), model_outs());
      else n_pass++;
      cyc(1'b0, 1'b0);
    end
  endtask

  task automatic test_recal();
    set_pattern(8'hFF, 100, 900);
    cyc(1'b1, 1'b1);
    n_checks++;
    if (bus.cal_done !== 1'b0 || bus.ir_color !== 8'h00 || bus.threshold !== 20'd300)
      $display("FAIL recal_start: done=%b ir=%h thr=%0d want 0/00/300", bus.cal_done, bus.ir_color, bus.threshold);
    else n_pass++;
    for (int s = 0; s < CALN; s++) begin
      set_cal_scan(40, 1000);
      cyc(1'b1, 1'b0);
      n_checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL recal scan %0d: got %h want %h", s, dut_outs(), model_outs());
      else n_pass++;
      if (s == CALN - 2) begin
        n_checks++;
        if (bus.threshold !== 20'd300 || bus.ir_color !== 8'h00)
          $display("FAIL recal_hold: thr=%0d ir=%h want 300/00", bus.threshold, bus.ir_color);
        else n_pass++;
      end
    end
    n_checks++;
    if (bus.threshold !== 20'd280 || bus.cal_done !== 1'b1)
      $display("FAIL recal_thresh: got %0d/%b want 280/1", bus.threshold, bus.cal_done);
    else n_pass++;
    set_pattern(8'hA6, 280, 281);
    cyc(1'b1, 1'b0);
    n_checks++;
    if (bus.ir_color !== 8'hA6) $display("FAIL recal_boundary: got %h want a6", bus.ir_color);
    else n_pass++;
  endtask

  task automatic test_reset_midcal();
    cyc(1'b0, 1'b1);
    for (int s = 0; s < 2; s++) begin
      set_cal_scan(10, 2000);
      cyc(1'b1, 1'b0);
    end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_outs() !== model_outs())
      $display("FAIL midcal_async_reset: got %h want %h", dut_outs(), model_outs());
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_cal("midcal_recal", 100, 900, 300);
  endtask
`else
  task automatic test_fixed();
    set_pattern(8'hFF, 600, 600);
    cyc(1'b1, 1'b0);
    n_checks++;
    if (bus.ir_color !== 8'hFF || bus.threshold !== 20'd500 || bus.cal_done !== 1'b1)
      $display("FAIL fixed_ir: ir=%h thr=%0d done=%b want ff/500/1", bus.ir_color, bus.threshold, bus.cal_done);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0);
      n_checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL fixed cyc %0d: got %h want %h", i, dut_outs(), model_outs());
      else n_pass++;
    end
    n_checks++;
    if (bus.goal !== 1'b0 || bus.right !== 1'b1 || bus.left !== 1'b1)
      $display("FAIL fixed_flags: goal=%b right=%b left=%b want 0/1/1", bus.goal, bus.right, bus.left);
    else n_pass++;
    set_pattern(8'h5A, 500, 501);
    cyc(1'b1, 1'b1);
    n_checks++;
    if (bus.ir_color !== 8'h5A || bus.cal_done !== 1'b1)
      $display("FAIL fixed_calstart_ignored: ir=%h done=%b want 5a/1", bus.ir_color, bus.cal_done);
    else n_pass++;
  endtask
`endif

  task automatic test_random(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(5, 0) == 0) begin
        set_random_scan();
        cyc(1'b1, 1'b0);
      end else begin
        cyc(1'b0, 1'b0);
      end
      n_checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL random cyc %0d: got %h want %h", i, dut_outs(), model_outs());
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      set_random_scan();
      cyc(1'b1, 1'b0);
      n_checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL b2b cyc %0d: got %h want %h", i, dut_outs(), model_outs());
      else n_pass++;
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.cal_start    = 1'b0;
    bus.ttd_bus      = '0;
    for (int k = 0; k < 8; k++) ttd[k] = 0;
    test_reset();
`ifdef LINE_SENSE_AUTOCAL_EN
    test_calibration();
    test_classify();
    test_glitch();
    test_random(200);
    test_recal();
    test_reset_midcal();
    test_back_to_back();
`else
    test_fixed();
    test_random(200);
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
